controlador_display: RTL and testbench

Scanning 8-digit seven-segment display driver for the Booth multiplier result path. Accepts a signed product through a valid/ready handshake and converts its magnitude to BCD with a sequential shift-add-3 (double-dabble) loop. It then time-multiplexes sign and digits onto common-anode displays, scanning digits with its own refresh prescaler and digit counter. It sits between the multiplier output register and the board pins.

---
 rtl/controlador_display_pkg.sv | 39 +++
 rtl/controlador_display_if.sv | 13 +
 rtl/controlador_display_conversor_bcd.sv | 79 +++++++
 rtl/controlador_display.sv | 132 +++++++++++++
 tb/tb_controlador_display.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/controlador_display_pkg.sv
// Shared types, constants and the 7-segment decoder for the display driver.
// Purely combinational content; no latency.
// No handshakes live here.
package paquete_display;

  typedef enum logic [1:0] {
    ESPERA,
    CONVIERTE,
    CARGA
  } estado_t;

  // Five decimal digits are enough for any 16-bit magnitude (max 32768).
  localparam int NUM_NIBBLES = 5;
  localparam int BCD_W       = 4 * NUM_NIBBLES;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANCO = 7'h7F;
  localparam logic [6:0] SEG_MENOS  = 7'b0111111;

  // Decimal nibble to active-low segment pattern; non-decimal nibbles stay dark.
  function automatic logic [6:0] bcd_a_segmentos(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANCO;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/controlador_display_if.sv
// Valid/ready product channel from the multiplier into the display driver.
// No latency of its own.
// Producer holds dato_valido/dato; consumer raises listo when it can take a word.
interface controlador_display_if #(
  parameter int ANCHO = 16
);
  logic             dato_valido;
  logic [ANCHO-1:0] dato;
  logic             listo;

  modport master (output dato_valido, output dato, input listo);
  modport slave  (input dato_valido, input dato, output listo);
endinterface

// File: rtl/controlador_display_conversor_bcd.sv
// Iterative shift-add-3 binary to BCD converter.
// ANCHO cycles after the inicio edge; hecho marks the edge of the final iteration.
// inicio is honoured only while not ocupado; the caller must not restart mid-run.
module conversor_bcd
  import paquete_display::*;
#(
  parameter int ANCHO = 16
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic             inicio,
  input  logic [ANCHO-1:0] magnitud,
  output logic             ocupado,
  output logic             hecho,
  output logic [BCD_W-1:0] bcd
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  logic [ANCHO-1:0] mag_q, mag_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ocupado_q, ocupado_d;
  logic [BCD_W-1:0] ajustado;
  logic [3:0]       nib;

  assign ocupado = ocupado_q;
  assign bcd     = bcd_q;
  // Final iteration happens on the edge that closes this cycle.
  assign hecho   = ocupado_q && (cnt_q == CW'(ANCHO - 1));

  // One double-dabble step per cycle: correct nibbles >=5, then shift in the next bit.
  always_comb begin
    ajustado  = bcd_q;
    nib       = 4'd0;
    mag_d     = mag_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    ocupado_d = ocupado_q;
    for (int i = 0; i < NUM_NIBBLES; i++) begin
      nib = bcd_q[4*i +: 4];
      if (nib >= 4'd5) begin
        nib = nib + 4'd3;
      end
      ajustado[4*i +: 4] = nib;
    end
    if (!ocupado_q) begin
      if (inicio) begin
        mag_d     = magnitud;
        bcd_d     = '0;
        cnt_d     = '0;
        ocupado_d = 1'b1;
      end
    end else begin
      bcd_d = {ajustado[BCD_W-2:0], mag_q[ANCHO-1]};
      mag_d = {mag_q[ANCHO-2:0], 1'b0};
      cnt_d = cnt_q + CW'(1);
      if (hecho) begin
        ocupado_d = 1'b0;
      end
    end
  end

  // Converter state registers.
  always_ff @(posedge reloj) begin
    if (reset) begin
      mag_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ocupado_q <= 1'b0;
    end else begin
      mag_q     <= mag_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      ocupado_q <= ocupado_d;
    end
  end

endmodule

// File: rtl/controlador_display.sv
// Signed product to multiplexed 8-digit common-anode seven-segment display.
// ANCHO+1 cycles from transfer to display update; next transfer ANCHO+2 edges later.
// listo drops for the whole conversion; dato_valido is ignored while it is low.
module controlador_display
  import paquete_display::*;
#(
  parameter int ANCHO        = 16,
  parameter int DIGITOS      = 8,
  parameter int DIV_REFRESCO = 100000
) (
  input  logic               reloj,
  input  logic               reset,
  controlador_display_if.slave bus,
  output logic [DIGITOS-1:0] anodos,
  output logic [6:0]         segmentos
);

  localparam int PW = (DIV_REFRESCO > 1) ? $clog2(DIV_REFRESCO) : 1;
  localparam int IW = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;

  estado_t          estado_q, estado_d;
  logic             signo_q, signo_d;
  logic             disp_signo_q, disp_signo_d;
  logic [BCD_W-1:0] disp_bcd_q, disp_bcd_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [DIGITOS-1:0] anodos_q, anodos_d;
  logic [6:0]       seg_q, seg_d;

  logic             listo;
  logic             transfer;
  logic             inicio;
  logic [ANCHO-1:0] magnitud;
  logic             ocupado;
  logic             hecho;
  logic [BCD_W-1:0] bcd;

  assign bus.listo = listo;
  assign anodos    = anodos_q;
  assign segmentos = seg_q;

  conversor_bcd #(
    .ANCHO (ANCHO)
  ) u_conversor (
    .reloj    (reloj),
    .reset    (reset),
    .inicio   (inicio),
    .magnitud (magnitud),
    .ocupado  (ocupado),
    .hecho    (hecho),
    .bcd      (bcd)
  );

  // Handshake FSM: accept a product, run the converter, then publish to the display register.
  always_comb begin
    listo        = (estado_q == ESPERA);
    transfer     = bus.dato_valido && listo;
    // Two's complement negate; the most negative value maps onto itself as unsigned.
    magnitud     = bus.dato[ANCHO-1] ? (~bus.dato + ANCHO'(1)) : bus.dato;
    inicio       = 1'b0;
    estado_d     = estado_q;
    signo_d      = signo_q;
    disp_signo_d = disp_signo_q;
    disp_bcd_d   = disp_bcd_q;
    unique case (estado_q)
      ESPERA: begin
        if (transfer) begin
          inicio   = 1'b1;
          signo_d  = bus.dato[ANCHO-1];
          estado_d = CONVIERTE;
        end
      end
      CONVIERTE: begin
        if (hecho || !ocupado) begin
          estado_d = CARGA;
        end
      end
      CARGA: begin
        disp_signo_d = signo_q;
        disp_bcd_d   = bcd;
        estado_d     = ESPERA;
      end
      default: estado_d = ESPERA;
    endcase
  end

  // Digit scan and segment selection; outputs derive from next-state so anode and
  // segment change together on one edge.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(DIV_REFRESCO - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(DIGITOS - 1)) ? '0 : idx_q + IW'(1);
    end
    anodos_d = ~(DIGITOS'(1) << idx_d);
    seg_d    = SEG_BLANCO;
    case (int'(idx_d))
      0: seg_d = bcd_a_segmentos(disp_bcd_d[3:0]);
      1: if (|disp_bcd_d[BCD_W-1:4])  seg_d = bcd_a_segmentos(disp_bcd_d[7:4]);
      2: if (|disp_bcd_d[BCD_W-1:8])  seg_d = bcd_a_segmentos(disp_bcd_d[11:8]);
      3: if (|disp_bcd_d[BCD_W-1:12]) seg_d = bcd_a_segmentos(disp_bcd_d[15:12]);
      4: if (|disp_bcd_d[BCD_W-1:16]) seg_d = bcd_a_segmentos(disp_bcd_d[19:16]);
      5: if (disp_signo_d && (|disp_bcd_d)) seg_d = SEG_MENOS;
      default: seg_d = SEG_BLANCO;
    endcase
  end

  // State, display register and scan registers.
  always_ff @(posedge reloj) begin
    if (reset) begin
      estado_q     <= ESPERA;
      signo_q      <= 1'b0;
      disp_signo_q <= 1'b0;
      disp_bcd_q   <= '0;
      presc_q      <= '0;
      idx_q        <= '0;
      anodos_q     <= ~(DIGITOS'(1));
      seg_q        <= bcd_a_segmentos(4'd0);
    end else begin
      estado_q     <= estado_d;
      signo_q      <= signo_d;
      disp_signo_q <= disp_signo_d;
      disp_bcd_q   <= disp_bcd_d;
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      anodos_q     <= anodos_d;
      seg_q        <= seg_d;
    end
  end

endmodule

// File: tb/tb_controlador_display.sv
// Bench for controlador_display with a fast refresh divider.
// Reference model tracks displayed integer value, busy countdown and scan position.
// Checks listo, anodos and segmentos every cycle.
module tb_controlador_display;

  localparam int ANCHO   = 16;
  localparam int DIGITOS = 8;
  localparam int DIV     = 4;
  localparam int LAT     = ANCHO + 1;

  logic               reloj = 1'b0;
  logic               reset;
  logic [DIGITOS-1:0] anodos;
  logic [6:0]         segmentos;

  controlador_display_if #(.ANCHO(ANCHO)) bus ();

  controlador_display #(
    .ANCHO        (ANCHO),
    .DIGITOS      (DIGITOS),
    .DIV_REFRESCO (DIV)
  ) dut (
    .reloj     (reloj),
    .reset     (reset),
    .bus       (bus),
    .anodos    (anodos),
    .segmentos (segmentos)
  );

  always #5 reloj = ~reloj;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_presc, m_idx, m_busy;
  int m_mag, m_pmag;
  bit m_neg, m_pneg;

  task automatic comprobar(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] patron(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] seg_esperado(input int idx, input int mag, input bit neg);
    int p;
    p = 1;
    if (idx < 5) begin
      for (int i = 0; i < idx; i++) p = p * 10;
      if (idx == 0 || mag >= p) return patron((mag / p) % 10);
      return 7'h7F;
    end
    if (idx == 5) return (neg && mag != 0) ? 7'b0111111 : 7'h7F;
    return 7'h7F;
  endfunction

  task automatic tick(input logic r, input logic v, input logic [ANCHO-1:0] d);
    int sv;
    logic [DIGITOS-1:0] an_exp;
    reset           = r;
    bus.dato_valido = v;
    bus.dato        = d;
    @(posedge reloj);
    if (r) begin
      m_presc = 0; m_idx = 0; m_busy = 0; m_mag = 0; m_neg = 0;
    end else begin
      if (m_busy == 0) begin
        if (v) begin
          sv     = int'($signed(d));
          m_pneg = (sv < 0);
          m_pmag = (sv < 0) ? -sv : sv;
          m_busy = LAT;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) begin
          m_mag = m_pmag;
          m_neg = m_pneg;
        end
      end
      if (m_presc == DIV - 1) begin
        m_presc = 0;
        m_idx   = (m_idx + 1) % DIGITOS;
      end else begin
        m_presc++;
      end
    end
    #1;
    an_exp = '1;
    an_exp[m_idx] = 1'b0;
    comprobar("listo", 32'(bus.listo), 32'(m_busy == 0));
    comprobar("anodos", 32'(anodos), 32'(an_exp));
    comprobar("segmentos", 32'(segmentos), 32'(seg_esperado(m_idx, m_mag, m_neg)));
  endtask

  task automatic reposo(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'($urandom));
  endtask

  // Wait out any conversion with noisy dato_valido/dato, then transfer d.
  task automatic enviar(input logic [ANCHO-1:0] d);
    int guard;
    guard = 0;
    while (m_busy != 0 && guard < 100) begin
      tick(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
      guard++;
    end
    if (guard >= 100) comprobar("timeout_listo", 32'(guard), 32'(0));
    tick(1'b0, 1'b1, d);
  endtask

  initial begin
    logic [ANCHO-1:0] v;
    reset           = 1'b1;
    bus.dato_valido = 1'b0;
    bus.dato        = '0;
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    // Idle scan of "0"
    reposo(2 * DIV * DIGITOS);

    enviar(16'd12345);       reposo(40);
    enviar(16'hFFF9);        reposo(40);
    enviar(16'h8000);        reposo(40);
    enviar(16'h7FFF);        reposo(40);
    enviar(16'd0);           reposo(40);

    // Back-to-back with dato_valido held high and changing data
    enviar(16'd4321);
    enviar(16'hFC18);
    enviar(16'd90);
    reposo(40);

    // Reset during a conversion of 999
    enviar(16'd999);
    reposo(4);
    tick(1'b1, 1'b1, 16'd555);
    reposo(40);

    // Reset takes priority over a simultaneous transfer
    tick(1'b1, 1'b1, 16'd777);
    reposo(3);
    tick(1'b0, 1'b0, '0);
    reposo(40);

    // Randomised products and gaps
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: v = 16'($urandom_range(0, 20));
        1: v = 16'hFFFF - 16'($urandom_range(0, 20));
        default: v = 16'($urandom);
      endcase
      enviar(v);
      reposo($urandom_range(0, 40));
    end
    reposo(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
